spi_reg_slave: RTL and testbench

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

---
 rtl/spi_reg_slave.sv | 197 +++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave: 16-bit frames {R/W, addr[6:0], data[7:0]},
// oversampled in the clk_in domain through 2-flop synchronizers.
// Optional feature macro: SPI_READBACK_EN -- when defined, read frames shift
// reg_rdata_in out on spi_miso_out; otherwise spi_miso_out is tied low.
module spi_reg_slave (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       spi_cs_in,
  input  logic       spi_sclk_in,
  input  logic       spi_mosi_in,
  output logic       spi_miso_out,
  output logic [6:0] reg_addr_out,
  output logic [7:0] reg_wdata_out,
  output logic       reg_we_out,
  input  logic [7:0] reg_rdata_in
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_e;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       armed_q, armed_d;
  logic [1:0] settle_q;

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  // Synchronize the SPI pins and keep one delayed copy for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the sync chain work.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      settle_q    <= 2'b00;
    end else begin
      cs_meta_q   <= spi_cs_in;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      sclk_meta_q <= spi_sclk_in;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= spi_mosi_in;
      mosi_sync_q <= mosi_meta_q;
      settle_q    <= {settle_q[0], 1'b1};
    end
  end

  assign cs_fall   =  cs_prev_q   & ~cs_sync_q;
  assign cs_rise   = ~cs_prev_q   &  cs_sync_q;
  assign sclk_rise = ~sclk_prev_q &  sclk_sync_q;
  assign sclk_fall =  sclk_prev_q & ~sclk_sync_q;

  // A frame may only start once CS has been seen high after reset, so a CS
  // still held low across reset release does not look like a fresh falling edge.
  assign armed_d = armed_q | (settle_q[1] & cs_sync_q);

  // Frame state register.
  always_ff @(posedge clk_in) begin
    if (reset_in) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and datapath updates for the frame decoder.
  // NOTE: every variable gets its default first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs_fall && armed_q) begin
          state_d   = S_CMD;
          bit_cnt_d = 4'd0;
        end
      end
      S_CMD: begin
        if (sclk_rise) begin
          shift_d   = {shift_q[5:0], mosi_sync_q};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d = S_DATA;
            rw_d    = shift_q[6];
            addr_d  = {shift_q[5:0], mosi_sync_q};
          end
        end
      end
      S_DATA: begin
        if (sclk_rise) begin
          shift_d   = {shift_q[5:0], mosi_sync_q};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            state_d = S_DONE;
            if (!rw_q) begin
              we_d    = 1'b1;
              wdata_d = {shift_q, mosi_sync_q};
            end
          end
        end
      end
      S_DONE: begin
        // Surplus SCLK edges are ignored until CS rises.
      end
      default: state_d = S_IDLE;
    endcase
    // CS rising aborts whatever is in flight; a partial frame never writes.
    if (cs_rise) begin
      state_d = S_IDLE;
      we_d    = 1'b0;
      wdata_d = wdata_q;
    end
  end

  // Datapath registers of the frame decoder.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      bit_cnt_q <= 4'd0;
      shift_q   <= 7'd0;
      rw_q      <= 1'b0;
      addr_q    <= 7'd0;
      wdata_q   <= 8'd0;
      we_q      <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      armed_q   <= armed_d;
    end
  end

  assign reg_addr_out  = addr_q;
  assign reg_wdata_out = wdata_q;
  assign reg_we_out    = we_q;

`ifdef SPI_READBACK_EN
  logic       miso_q, miso_d;
  logic       rd_load_q, rd_load_d;
  logic [7:0] rd_shift_q, rd_shift_d;

  // Capture read data one cycle after the address lands, then shift it out
  // MSB first on each falling SCLK edge of the data phase.
  always_comb begin
    miso_d     = miso_q;
    rd_shift_d = rd_shift_q;
    rd_load_d  = (state_q == S_CMD) && sclk_rise && (bit_cnt_q == 4'd7) && shift_q[6];
    if (rd_load_q) rd_shift_d = reg_rdata_in;
    if ((state_q == S_DATA) && rw_q && sclk_fall) begin
      miso_d     = rd_shift_q[7];
      rd_shift_d = {rd_shift_q[6:0], 1'b0};
    end
    if (state_d != S_DATA) miso_d = 1'b0;
  end

  // Readback registers.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      miso_q     <= 1'b0;
      rd_load_q  <= 1'b0;
      rd_shift_q <= 8'd0;
    end else begin
      miso_q     <= miso_d;
      rd_load_q  <= rd_load_d;
      rd_shift_q <= rd_shift_d;
    end
  end

  assign spi_miso_out = miso_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^reg_rdata_in;
  assign spi_miso_out = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: SCLK = clk_in/8, frames driven MSB first.
module tb_spi_reg_slave;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic       miso;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       we;

  int         vectors = 0;
  int         miscompares = 0;
  int         we_count = 0;
  logic [7:0] we_log[$];

`ifdef SPI_READBACK_EN
  localparam logic [7:0] READ_EXP = 8'hC3;
`else
  localparam logic [7:0] READ_EXP = 8'h00;
`endif

  spi_reg_slave dut (
    .clk_in        (clk),
    .reset_in      (reset),
    .spi_cs_in     (cs),
    .spi_sclk_in   (sclk),
    .spi_mosi_in   (mosi),
    .spi_miso_out  (miso),
    .reg_addr_out  (addr),
    .reg_wdata_out (wdata),
    .reg_we_out    (we),
    .reg_rdata_in  (rdata)
  );

  always #5 clk = ~clk;

  // Every clk cycle with the strobe high counts, so a wide pulse shows up as extra writes.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      we_count++;
      we_log.push_back(wdata);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master side: nbits of frame, then extra zero pulses; MISO sampled just before each rise.
  task automatic spi_xfer(input logic [15:0] frame, input int nbits, input int extra,
                          input bit raise_cs, output logic [15:0] rx);
    logic [15:0] sh;
    sh = frame;
    rx = 16'h0000;
    cs = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits + extra; i++) begin
      mosi = (i < nbits) ? sh[15] : 1'b0;
      sh   = sh << 1;
      wait_clk(4);
      rx   = {rx[14:0], miso};
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(4);
    mosi = 1'b0;
    if (raise_cs) begin
      cs = 1'b1;
      wait_clk(8);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_clk(3);
    vectors++; if (addr !== 7'h00) begin miscompares++; $display("FAIL reset_addr: got %h want %h", addr, 7'h00); end
    vectors++; if (wdata !== 8'h00) begin miscompares++; $display("FAIL reset_wdata: got %h want %h", wdata, 8'h00); end
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", we); end
    vectors++; if (miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso: got %b want 0", miso); end
    reset = 1'b0;
    wait_clk(6);
  endtask

  task automatic test_write;
    int base;
    logic [15:0] rx;
    base = we_count;
    spi_xfer(16'h0A5C, 16, 0, 1'b1, rx);
    vectors++; if (we_count - base !== 1) begin miscompares++; $display("FAIL write_we_count: got %0d want 1", we_count - base); end
    vectors++; if (addr !== 7'h0A) begin miscompares++; $display("FAIL write_addr: got %h want %h", addr, 7'h0A); end
    vectors++; if (wdata !== 8'h5C) begin miscompares++; $display("FAIL write_wdata: got %h want %h", wdata, 8'h5C); end
    vectors++; if (rx !== 16'h0000) begin miscompares++; $display("FAIL write_miso_idle: got %h want %h", rx, 16'h0000); end
  endtask

  task automatic test_read;
    int base;
    logic [15:0] rx;
    base  = we_count;
    rdata = 8'hC3;
    spi_xfer(16'h8300, 16, 0, 1'b1, rx);
    vectors++; if (rx[7:0] !== READ_EXP) begin miscompares++; $display("FAIL read_data: got %h want %h", rx[7:0], READ_EXP); end
    vectors++; if (rx[15:8] !== 8'h00) begin miscompares++; $display("FAIL read_cmd_miso: got %h want %h", rx[15:8], 8'h00); end
    vectors++; if (we_count - base !== 0) begin miscompares++; $display("FAIL read_no_we: got %0d want 0", we_count - base); end
    vectors++; if (addr !== 7'h03) begin miscompares++; $display("FAIL read_addr: got %h want %h", addr, 7'h03); end
    vectors++; if (wdata !== 8'h5C) begin miscompares++; $display("FAIL read_wdata_kept: got %h want %h", wdata, 8'h5C); end
    rdata = 8'h00;
  endtask

  task automatic test_abort;
    int base;
    logic [15:0] rx;
    base = we_count;
    spi_xfer(16'h1234, 11, 0, 1'b1, rx);
    vectors++; if (we_count - base !== 0) begin miscompares++; $display("FAIL abort_no_we: got %0d want 0", we_count - base); end
    vectors++; if (wdata !== 8'h5C) begin miscompares++; $display("FAIL abort_wdata_kept: got %h want %h", wdata, 8'h5C); end
    vectors++; if (addr !== 7'h12) begin miscompares++; $display("FAIL abort_addr: got %h want %h", addr, 7'h12); end
    base = we_count;
    spi_xfer(16'h0511, 16, 0, 1'b1, rx);
    vectors++; if (we_count - base !== 1) begin miscompares++; $display("FAIL after_abort_we: got %0d want 1", we_count - base); end
    vectors++; if (addr !== 7'h05) begin miscompares++; $display("FAIL after_abort_addr: got %h want %h", addr, 7'h05); end
    vectors++; if (wdata !== 8'h11) begin miscompares++; $display("FAIL after_abort_wdata: got %h want %h", wdata, 8'h11); end
  endtask

  task automatic test_extra_clocks;
    int base;
    logic [15:0] rx;
    base = we_count;
    spi_xfer(16'h7FFF, 16, 3, 1'b1, rx);
    vectors++; if (we_count - base !== 1) begin miscompares++; $display("FAIL extra_we_count: got %0d want 1", we_count - base); end
    vectors++; if (addr !== 7'h7F) begin miscompares++; $display("FAIL extra_addr: got %h want %h", addr, 7'h7F); end
    vectors++; if (wdata !== 8'hFF) begin miscompares++; $display("FAIL extra_wdata: got %h want %h", wdata, 8'hFF); end
  endtask

  task automatic test_reset_mid_frame;
    int base;
    logic [15:0] rx;
    base = we_count;
    spi_xfer(16'h0101, 12, 0, 1'b0, rx);
    reset = 1'b1;
    wait_clk(2);
    vectors++; if (addr !== 7'h00) begin miscompares++; $display("FAIL midrst_addr: got %h want %h", addr, 7'h00); end
    vectors++; if (wdata !== 8'h00) begin miscompares++; $display("FAIL midrst_wdata: got %h want %h", wdata, 8'h00); end
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL midrst_we: got %b want 0", we); end
    vectors++; if (miso !== 1'b0) begin miscompares++; $display("FAIL midrst_miso: got %b want 0", miso); end
    reset = 1'b0;
    wait_clk(4);
    cs = 1'b1;
    wait_clk(8);
    vectors++; if (we_count - base !== 0) begin miscompares++; $display("FAIL midrst_no_we: got %0d want 0", we_count - base); end
    vectors++; if (wdata !== 8'h00) begin miscompares++; $display("FAIL midrst_wdata_after: got %h want %h", wdata, 8'h00); end
    base = we_count;
    spi_xfer(16'h0202, 16, 0, 1'b1, rx);
    vectors++; if (we_count - base !== 1) begin miscompares++; $display("FAIL postrst_we: got %0d want 1", we_count - base); end
    vectors++; if (addr !== 7'h02) begin miscompares++; $display("FAIL postrst_addr: got %h want %h", addr, 7'h02); end
    vectors++; if (wdata !== 8'h02) begin miscompares++; $display("FAIL postrst_wdata: got %h want %h", wdata, 8'h02); end
  endtask

  task automatic test_back_to_back;
    int base;
    int first;
    logic [15:0] rx;
    logic [7:0] d0;
    logic [7:0] d1;
    base  = we_count;
    first = we_log.size();
    spi_xfer(16'h0011, 16, 0, 1'b1, rx);
    spi_xfer(16'h0122, 16, 0, 1'b1, rx);
    vectors++; if (we_count - base !== 2) begin miscompares++; $display("FAIL b2b_we_count: got %0d want 2", we_count - base); end
    d0 = (we_log.size() > first)     ? we_log[first]     : 8'hXX;
    d1 = (we_log.size() > first + 1) ? we_log[first + 1] : 8'hXX;
    vectors++; if (d0 !== 8'h11) begin miscompares++; $display("FAIL b2b_first_data: got %h want %h", d0, 8'h11); end
    vectors++; if (d1 !== 8'h22) begin miscompares++; $display("FAIL b2b_second_data: got %h want %h", d1, 8'h22); end
    vectors++; if (addr !== 7'h01) begin miscompares++; $display("FAIL b2b_addr: got %h want %h", addr, 7'h01); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_extra_clocks();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
